bsram_dma: RTL and testbench
============================

# bsram_dma

Copy/fill engine that acts as the initiator on a BSRAM read/write port pair. It accepts a command (source, destination, length, mode) through a start/busy/done handshake and streams one word per cycle: copy reads source words and writes them to the destination, fill writes a constant pattern. It sits between the core's memory-mapped control logic and a single BSRAM instance, driving that instance's read and write ports directly.

## Interface
- CORE, 0, core index printed in report output
- DATA_WIDTH, 32, word width; matches the BSRAM
- ADDR_WIDTH, 8, word address width; matches the BSRAM
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_WIDTH  first source word (copy only)
- dst_addr  in  ADDR_WIDTH  first destination word
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
- fill_data  in  DATA_WIDTH  pattern (fill only)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- readEnable, readAddress  out  1 / ADDR_WIDTH  to BSRAM read port
- readData  in  DATA_WIDTH  from BSRAM; same-cycle combinational
- writeEnable, writeAddress, writeData  out  1 / ADDR_WIDTH / DATA_WIDTH  to BSRAM write port
- report  in  1  print per-cycle state via $display when high

## Operation
- States: IDLE, COPY, DRAIN, FILL, DONE.
- IDLE: start=1 latches src, dst, length, mode, fill_data; length=0 -> DONE; mode=1 -> FILL; else COPY. start ignored in every other state.
- COPY: readEnable=1, readAddress=src+i; readData captured into data_q at the edge. writeEnable=1 from the second COPY cycle on, writing data_q to dst+i-1. After L reads -> DRAIN.
- DRAIN: final write of data_q to dst+L-1, readEnable=0 -> DONE.
- FILL: writeEnable=1, writeAddress=dst+i, writeData=fill_data for L cycles -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH; no error raised.
- Overlap: result equals a sequential ascending word-by-word loop. With dst=src+1, the BSRAM write-to-read bypass delivers the just-written word, replicating src[0]. This is intended; no memmove semantics.
- All memory-side outputs and busy/done come from registers. writeData is held at its last value when writeEnable=0. readAddress and writeAddress are don't-care when their enable is low.
- Reset (reset=0 at an edge): state=IDLE; busy, done, readEnable, writeEnable = 0; addresses, data_q, writeData = 0. Mid-command reset aborts immediately; partially written words remain.

## Timing
- Start edge is cycle 0.
- Copy, L>=1: readEnable in cycles 1..L; writeEnable in cycles 2..L+1; busy in cycles 1..L+1; done in cycle L+2.
- Fill, L>=1: writeEnable in cycles 1..L; busy in cycles 1..L; done in cycle L+1.
- L=0: busy never asserts; done in cycle 1; no memory access.
- A new start is accepted in the done cycle+1 (IDLE), giving back-to-back commands a 1-cycle gap.
- Throughput: 1 word/cycle in both modes.
- length=2^ADDR_WIDTH covers the whole memory, and the index counter is ADDR_WIDTH+1 bits wide.

## Structure
- Shared package bsram_dma_pkg: state encoding (IDLE, COPY, DRAIN, FILL, DONE) and mode constants MODE_COPY=0, MODE_FILL=1.
- Single module with no sub-modules. The index counter, the address adders, and data_q are inline.
- The bench instantiates BSRAM (ADDR_WIDTH=8, zero-initialised) as the memory model.

## Test plan
- Copy, src=0x10, dst=0x40, L=4, mem[0x10..0x13]=1,2,3,4 -> mem[0x40..0x43]=1,2,3,4; done in cycle 6; busy in cycles 1..5.
- Fill, dst=0xFE, L=3, fill_data=0xDEADBEEF -> mem[0xFE], mem[0xFF], mem[0x00] = 0xDEADBEEF (wrap); mem[0x01] unchanged; done in cycle 4.
- L=0 in both modes -> done in cycle 1; readEnable and writeEnable never asserted; busy stays 0.
- Overlap copy, src=0x20, dst=0x21, L=4, mem[0x20]=0xA -> mem[0x21..0x24] all 0xA.
- start pulsed at cycle 2 of a copy with L=8 -> ignored; only one done pulse, in cycle 10.
- Reset asserted at cycle 3 of a copy with L=8 -> next cycle busy=0, done=0, enables=0; a following fill command completes normally.

Source files
------------

// File: rtl/bsram_dma_pkg.sv
// Shared types for the BSRAM copy/fill engine: state encoding, mode constants
// and the debug view exported by the engine.
package bsram_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COPY  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // trace mirrors the report input so an external tracer knows which cycles to print
    typedef struct packed {
        logic [7:0] core;
        logic       trace;
        state_e     state;
    } dbg_t;

endpackage

// File: rtl/bsram_dma.sv
// Copy/fill engine driving one BSRAM read/write port pair, one word per cycle.
// Handshake: start is sampled only in IDLE; busy spans the command; done is a one-cycle pulse.
module bsram_dma
    import bsram_dma_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic                  report,
    output dbg_t                  dbg
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] ra_q, ra_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH:0]   idx_m1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            ra_q    <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            ra_q    <= ra_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            data_q  <= data_d;
        end
    end

    // cnt_q counts words already issued; in COPY the write lags the read by one word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        re_d    = 1'b0;
        ra_d    = ra_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        data_d  = data_q;
        idx_m1  = cnt_q - 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = length;
                    cnt_d = (ADDR_WIDTH+1)'(1);
                    if (length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_FILL;
                        busy_d  = 1'b1;
                        we_d    = 1'b1;
                        wa_d    = dst_addr;
                        data_d  = fill_data;
                    end else begin
                        state_d = ST_COPY;
                        busy_d  = 1'b1;
                        re_d    = 1'b1;
                        ra_d    = src_addr;
                    end
                end
            end
            ST_COPY: begin
                data_d = readData;
                we_d   = 1'b1;
                wa_d   = dst_q + idx_m1[ADDR_WIDTH-1:0];
                if (cnt_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    re_d  = 1'b1;
                    ra_d  = src_q + cnt_q[ADDR_WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            ST_FILL: begin
                if (cnt_q == len_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    we_d  = 1'b1;
                    wa_d  = dst_q + cnt_q[ADDR_WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign readEnable   = re_q;
    assign readAddress  = ra_q;
    assign writeEnable  = we_q;
    assign writeAddress = wa_q;
    assign writeData    = data_q;

    assign dbg.core  = 8'(CORE);
    assign dbg.trace = report;
    assign dbg.state = state_q;

endmodule

// File: tb/tb_bsram_dma.sv
// Bench for bsram_dma: directed table, reset-abort sequence and random commands,
// checked against a word-by-word loop model of the memory.
module tb_bsram_dma;
    import bsram_dma_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 1 << AW;

    logic          clock;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic          readEnable;
    logic [AW-1:0] readAddress;
    logic [DW-1:0] readData;
    logic          writeEnable;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeData;
    logic          report;
    dbg_t          dbg;

    bsram_dma #(.CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
        .busy(busy), .done(done),
        .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
        .report(report), .dbg(dbg)
    );

    // ---- clock ----
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---- BSRAM model: synchronous write, combinational read with write-to-read bypass ----
    logic [DW-1:0] mem [NW];
    logic          tb_clr;
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [DW-1:0] tb_wd;

    always @(posedge clock) begin
        if (tb_clr) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    assign readData = (writeEnable && writeAddress == readAddress) ? writeData : mem[readAddress];

    always @(negedge clock) begin
        if (dbg.trace)
            $display("core %0d: state=%0d busy=%0b done=%0b re=%0b we=%0b",
                     dbg.core, dbg.state, busy, done, readEnable, writeEnable);
    end

    // ---- scoreboard ----
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ref_mem [NW];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: a plain ascending loop, one word at a time, addresses mod 2^AW.
    task automatic ref_cmd(input logic m, input int s, input int d, input int l, input logic [DW-1:0] f);
        for (int i = 0; i < l; i++)
            ref_mem[(d + i) % NW] = (m == MODE_FILL) ? f : ref_mem[(s + i) % NW];
    endtask

    task automatic check_mem(input string tag);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < NW; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s.mem_mismatches(first@%0d)", tag, first), bad, 0);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clock);
        tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // ---- driver / monitor for one command ----
    int o_done_cyc, o_done_n;
    int o_busy_f, o_busy_l, o_busy_n;
    int o_re_f, o_re_l, o_re_n;
    int o_we_f, o_we_l, o_we_n;

    task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] l, input logic [DW-1:0] f, input int again_cyc);
        int budget;
        budget = int'(l) + 6;
        o_done_cyc = -1; o_done_n = 0;
        o_busy_f = -1; o_busy_l = -1; o_busy_n = 0;
        o_re_f = -1; o_re_l = -1; o_re_n = 0;
        o_we_f = -1; o_we_l = -1; o_we_n = 0;
        @(negedge clock);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = l; fill_data = f;
        @(posedge clock);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start = (c == again_cyc);
            if (busy) begin
                if (o_busy_f < 0) o_busy_f = c;
                o_busy_l = c; o_busy_n++;
            end
            if (readEnable) begin
                if (o_re_f < 0) o_re_f = c;
                o_re_l = c; o_re_n++;
            end
            if (writeEnable) begin
                if (o_we_f < 0) o_we_f = c;
                o_we_l = c; o_we_n++;
            end
            if (done) begin
                if (o_done_cyc < 0) o_done_cyc = c;
                o_done_n++;
            end
        end
        start = 1'b0;
    endtask

    // Timing windows from the command rules; a window of -1/-1/0 means never asserted.
    task automatic check_timing(input string tag, input logic m, input int l, input int exp_done);
        int bf, bl, rf, rl, wf, wl;
        if (l == 0) begin
            bf = -1; bl = -1; rf = -1; rl = -1; wf = -1; wl = -1;
        end else if (m == MODE_COPY) begin
            bf = 1; bl = l + 1; rf = 1; rl = l; wf = 2; wl = l + 1;
        end else begin
            bf = 1; bl = l; rf = -1; rl = -1; wf = 1; wl = l;
        end
        check({tag, ".done_cycle"}, o_done_cyc, exp_done);
        check({tag, ".done_pulses"}, o_done_n, 1);
        check({tag, ".busy_first"}, o_busy_f, bf);
        check({tag, ".busy_last"}, o_busy_l, bl);
        check({tag, ".busy_count"}, o_busy_n, (bf < 0) ? 0 : bl - bf + 1);
        check({tag, ".re_first"}, o_re_f, rf);
        check({tag, ".re_count"}, o_re_n, (rf < 0) ? 0 : rl - rf + 1);
        check({tag, ".we_first"}, o_we_f, wf);
        check({tag, ".we_last"}, o_we_l, wl);
        check({tag, ".we_count"}, o_we_n, (wf < 0) ? 0 : wl - wf + 1);
    endtask

    typedef struct {
        logic          m;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [AW:0]   l;
        logic [DW-1:0] f;
        int            again;
        int            exp_done;
    } vec_t;

    vec_t tbl [7];

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_data = '0; report = 1'b0;
        tb_clr = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;

        tbl[0] = '{MODE_COPY, 8'h10, 8'h40, 9'd4, 32'h0,        0, 6};
        tbl[1] = '{MODE_FILL, 8'h00, 8'hFE, 9'd3, 32'hDEADBEEF, 0, 4};
        tbl[2] = '{MODE_COPY, 8'h05, 8'h06, 9'd0, 32'h0,        0, 1};
        tbl[3] = '{MODE_FILL, 8'h00, 8'h30, 9'd0, 32'h11111111, 0, 1};
        tbl[4] = '{MODE_COPY, 8'h20, 8'h21, 9'd4, 32'h0,        0, 6};
        tbl[5] = '{MODE_COPY, 8'h60, 8'h90, 9'd8, 32'h0,        2, 10};
        tbl[6] = '{MODE_COPY, 8'h40, 8'hF0, 9'd1, 32'h0,        0, 3};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.readEnable", readEnable, 0);
        check("reset.writeEnable", writeEnable, 0);
        check("reset.readAddress", readAddress, 0);
        check("reset.writeAddress", writeAddress, 0);
        check("reset.writeData", writeData, 0);
        reset = 1'b1;
        tb_clr = 1'b0;

        for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), 32'(i + 1));
        poke(8'h20, 32'hA);
        for (int i = 0; i < 8; i++) poke(8'h60 + 8'(i), 32'h100 + 32'(i));

        for (int k = 0; k < 7; k++) begin
            report = (k == 6);
            run_cmd(tbl[k].m, tbl[k].s, tbl[k].d, tbl[k].l, tbl[k].f, tbl[k].again);
            ref_cmd(tbl[k].m, int'(tbl[k].s), int'(tbl[k].d), int'(tbl[k].l), tbl[k].f);
            check_timing($sformatf("vec%0d", k), tbl[k].m, int'(tbl[k].l), tbl[k].exp_done);
            check_mem($sformatf("vec%0d", k));
        end
        report = 1'b0;

        for (int i = 0; i < 4; i++) check($sformatf("copy.mem[0x%0h]", 8'h40 + i), mem[8'h40 + i], i + 1);
        check("fill.mem[0xFE]", mem[8'hFE], 32'hDEADBEEF);
        check("fill.mem[0xFF]", mem[8'hFF], 32'hDEADBEEF);
        check("fill.mem[0x00]", mem[8'h00], 32'hDEADBEEF);
        check("fill.mem[0x01]", mem[8'h01], 0);
        for (int i = 1; i <= 4; i++) check($sformatf("overlap.mem[0x%0h]", 8'h20 + i), mem[8'h20 + i], 32'hA);

        // Reset during cycle 3 of an 8-word copy: writes of cycles 2 and 3 land, then all stops.
        @(negedge clock);
        start = 1'b1; mode = MODE_COPY; src_addr = 8'h10; dst_addr = 8'hA0; length = 9'd8;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.readEnable", readEnable, 0);
        check("abort.writeEnable", writeEnable, 0);
        check("abort.writeData", writeData, 0);
        reset = 1'b1;
        ref_cmd(MODE_COPY, 8'h10, 8'hA0, 2, '0);
        run_cmd(MODE_FILL, 8'h00, 8'hA4, 9'd3, 32'h12345678, 0);
        ref_cmd(MODE_FILL, 0, 8'hA4, 3, 32'h12345678);
        check_timing("post_abort_fill", MODE_FILL, 3, 4);
        check_mem("post_abort_fill");

        for (int k = 0; k < 18; k++) begin
            logic          m;
            logic [AW-1:0] s, d;
            logic [AW:0]   l;
            logic [DW-1:0] f;
            m = 1'($urandom_range(0, 1));
            s = 8'($urandom_range(0, NW - 1));
            d = 8'($urandom_range(0, NW - 1));
            l = 9'($urandom_range(0, 24));
            f = $urandom;
            if (k == 16) begin m = MODE_COPY; l = 9'd256; end
            if (k == 17) begin m = MODE_FILL; l = 9'd256; end
            if (m == MODE_COPY) begin
                poke(s, $urandom);
                poke(s + 8'd1, $urandom);
            end
            run_cmd(m, s, d, l, f, 0);
            ref_cmd(m, int'(s), int'(d), int'(l), f);
            check_timing($sformatf("rand%0d", k), m, int'(l),
                         (l == 0) ? 1 : ((m == MODE_COPY) ? int'(l) + 2 : int'(l) + 1));
            check_mem($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
